// File: rtl/decode_pkg.sv
// Shared constants for the MIPS decode stage: opcodes, forwarding selects, NOP.
package decode_pkg;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  // Operand source select driven by the hazard unit; 2'b11 falls back to the regfile.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_W  = 2'b10
  } fwd_sel_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/decode_regfile.sv
// Reset-cleared register file with hardwired zero register and write-through bypass.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int DEPTH = 2 ** REG_AW;

  logic [DATA_W-1:0] regs [DEPTH];

  // Array update: synchronous clear of every entry, otherwise write non-zero addresses.
  // NOTE: resetting a memory forces it into flops (no RAM macro); required here because
  // the architecture guarantees all registers read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: register 0 is always zero; a same-cycle write to the read address bypasses the array.
  assign rdata1 = (raddr1 == '0)                ? '0    :
                  (we && waddr == raddr1)       ? wdata : regs[raddr1];
  assign rdata2 = (raddr2 == '0)                ? '0    :
                  (we && waddr == raddr2)       ? wdata : regs[raddr2];

endmodule

// File: rtl/decode_stage_pipe.sv
// MIPS decode stage: IF/ID register, register file, early branch compare and target generation.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       InstrF,
  input  logic [DATA_W-1:0] PCPlus4F,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [1:0]        ForwardAD,
  input  logic [1:0]        ForwardBD,
  output logic [31:0]       InstrD,
  output logic [DATA_W-1:0] PCPlus4D,
  output logic              ValidD,
  output logic [DATA_W-1:0] RD1_D,
  output logic [DATA_W-1:0] RD2_D,
  output logic [DATA_W-1:0] SignImmD,
  output logic [DATA_W-1:0] PCBranchD,
  output logic [DATA_W-1:0] PCJumpD,
  output logic [REG_AW-1:0] RsD,
  output logic [REG_AW-1:0] RtD,
  output logic [REG_AW-1:0] RdD,
  output logic              EqualD,
  output logic              BranchTakenD,
  output logic              JumpD
);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [5:0]        opcode;

  // IF/ID register: reset > stall > flush > load.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      InstrD   <= NOP;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      if (FlushD) begin
        InstrD   <= NOP;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end else begin
        InstrD   <= InstrF;
        PCPlus4D <= PCPlus4F;
        ValidD   <= 1'b1;
      end
    end
  end

  assign opcode = InstrD[31:26];
  assign RsD    = InstrD[21 +: REG_AW];
  assign RtD    = InstrD[16 +: REG_AW];
  assign RdD    = InstrD[11 +: REG_AW];

  decode_regfile #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_regfile (
    .clk    (CLK),
    .rst    (RST),
    .we     (RegWriteW),
    .waddr  (WriteRegW),
    .wdata  (ResultW),
    .raddr1 (RsD),
    .raddr2 (RtD),
    .rdata1 (RD1_D),
    .rdata2 (RD2_D)
  );

  // Forwarding muxes feeding the early branch comparator.
  // NOTE: the default branch assigns every output, so no latch is inferred.
  always_comb begin
    unique case (ForwardAD)
      FWD_M:   src_a = ALUOutM;
      FWD_W:   src_a = ResultW;
      default: src_a = RD1_D;
    endcase
    unique case (ForwardBD)
      FWD_M:   src_b = ALUOutM;
      FWD_W:   src_b = ResultW;
      default: src_b = RD2_D;
    endcase
  end

  assign EqualD    = (src_a == src_b);
  assign SignImmD  = {{(DATA_W-16){InstrD[15]}}, InstrD[15:0]};
  assign PCBranchD = (SignImmD << 2) + PCPlus4D;
  assign PCJumpD   = {PCPlus4D[DATA_W-1:28], InstrD[25:0], 2'b00};

  // Control-transfer decode; not stall-gated, the hazard unit masks these while stalling.
  assign BranchTakenD = ValidD & (((opcode == OP_BEQ) & EqualD) | ((opcode == OP_BNE) & ~EqualD));
  assign JumpD        = ValidD & (opcode == OP_J);

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench: directed test plan plus randomized traffic against a behavioural model.
module tb_decode_stage_pipe;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 32-bit / 32-register instance
  logic        RST, StallD, FlushD, RegWriteW;
  logic [31:0] InstrF, PCPlus4F, ResultW, ALUOutM;
  logic [4:0]  WriteRegW;
  logic [1:0]  ForwardAD, ForwardBD;
  logic [31:0] InstrD, PCPlus4D, RD1_D, RD2_D, SignImmD, PCBranchD, PCJumpD;
  logic [4:0]  RsD, RtD, RdD;
  logic        ValidD, EqualD, BranchTakenD, JumpD;

  decode_stage_pipe #(.DATA_W(32), .REG_AW(5)) dut (
    .CLK(CLK), .RST(RST), .InstrF(InstrF), .PCPlus4F(PCPlus4F), .StallD(StallD), .FlushD(FlushD),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW), .ALUOutM(ALUOutM),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .RD1_D(RD1_D), .RD2_D(RD2_D), .SignImmD(SignImmD), .PCBranchD(PCBranchD),
    .PCJumpD(PCJumpD), .RsD(RsD), .RtD(RtD), .RdD(RdD), .EqualD(EqualD),
    .BranchTakenD(BranchTakenD), .JumpD(JumpD)
  );

  // 64-bit / 8-register instance
  logic        p_rst, p_stall, p_flush, p_we;
  logic [31:0] p_instr_f, p_instr_d;
  logic [63:0] p_pc_f, p_wd, p_alu, p_pc_d, p_rd1, p_rd2, p_imm, p_pcb, p_pcj;
  logic [2:0]  p_wa, p_rs, p_rt, p_rd;
  logic [1:0]  p_fa, p_fb;
  logic        p_valid, p_eq, p_bt, p_j;

  decode_stage_pipe #(.DATA_W(64), .REG_AW(3)) dut64 (
    .CLK(CLK), .RST(p_rst), .InstrF(p_instr_f), .PCPlus4F(p_pc_f), .StallD(p_stall), .FlushD(p_flush),
    .RegWriteW(p_we), .WriteRegW(p_wa), .ResultW(p_wd), .ALUOutM(p_alu),
    .ForwardAD(p_fa), .ForwardBD(p_fb), .InstrD(p_instr_d), .PCPlus4D(p_pc_d),
    .ValidD(p_valid), .RD1_D(p_rd1), .RD2_D(p_rd2), .SignImmD(p_imm), .PCBranchD(p_pcb),
    .PCJumpD(p_pcj), .RsD(p_rs), .RtD(p_rt), .RdD(p_rd), .EqualD(p_eq),
    .BranchTakenD(p_bt), .JumpD(p_j)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state for the 32-bit instance
  logic [31:0] m_rf [32];
  logic [31:0] m_instr, m_pc;
  logic        m_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (RegWriteW && WriteRegW == a) return ResultW;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf_val);
    if (sel == 2'd1) return ALUOutM;
    if (sel == 2'd2) return ResultW;
    return rf_val;
  endfunction

  // Compare every output of the 32-bit instance against the model.
  task automatic compare_outputs(input string tag);
    logic [31:0] imm, rd1, rd2, a, b, pcb, pcj;
    logic [5:0]  op;
    logic        eq, bt;
    imm = 32'(int'($signed(m_instr[15:0])));
    rd1 = model_read(m_instr[25:21]);
    rd2 = model_read(m_instr[20:16]);
    a   = pick(ForwardAD, rd1);
    b   = pick(ForwardBD, rd2);
    eq  = (a == b);
    op  = m_instr[31:26];
    bt  = m_valid && ((op == 6'd4 && eq) || (op == 6'd5 && !eq));
    pcb = m_pc + imm * 32'd4;
    pcj = (m_pc & 32'hF000_0000) | ({6'd0, m_instr[25:0]} << 2);
    check({tag, ".instr"}, InstrD, m_instr);
    check({tag, ".pc4"}, PCPlus4D, m_pc);
    check({tag, ".valid"}, ValidD, m_valid);
    check({tag, ".rs"}, RsD, m_instr[25:21]);
    check({tag, ".rt"}, RtD, m_instr[20:16]);
    check({tag, ".rd"}, RdD, m_instr[15:11]);
    check({tag, ".rd1"}, RD1_D, rd1);
    check({tag, ".rd2"}, RD2_D, rd2);
    check({tag, ".imm"}, SignImmD, imm);
    check({tag, ".pcb"}, PCBranchD, pcb);
    check({tag, ".pcj"}, PCJumpD, pcj);
    check({tag, ".eq"}, EqualD, eq);
    check({tag, ".bt"}, BranchTakenD, bt);
    check({tag, ".j"}, JumpD, m_valid && op == 6'd2);
  endtask

  // Advance one clock; the model sees the inputs that were stable across the edge.
  task automatic tick();
    @(posedge CLK);
    if (RST) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_instr = 32'd0; m_pc = 32'd0; m_valid = 1'b0;
    end else begin
      if (RegWriteW && WriteRegW != 0) m_rf[WriteRegW] = ResultW;
      if (!StallD) begin
        if (FlushD) begin
          m_instr = 32'd0; m_pc = 32'd0; m_valid = 1'b0;
        end else begin
          m_instr = InstrF; m_pc = PCPlus4F; m_valid = 1'b1;
        end
      end
    end
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [31:0] rand_val();
    return ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 32'hx;
    m_instr = 32'hx; m_pc = 32'hx; m_valid = 1'bx;
    RST = 1; StallD = 0; FlushD = 0; RegWriteW = 0; WriteRegW = 0; ResultW = 0; ALUOutM = 0;
    ForwardAD = 0; ForwardBD = 0; InstrF = 32'h1000_0003; PCPlus4F = 32'h40;
    p_rst = 1; p_stall = 0; p_flush = 0; p_we = 0; p_wa = 0; p_wd = 0; p_alu = 0;
    p_fa = 0; p_fb = 0; p_instr_f = 0; p_pc_f = 0;

    // Reset
    tick(); tick();
    check("rst.valid", ValidD, 1'b0);
    check("rst.instr", InstrD, 32'd0);
    compare_outputs("rst");
    RST = 0;
    tick();
    check("beq.eq", EqualD, 1'b1);
    check("beq.bt", BranchTakenD, 1'b1);
    check("beq.pcb", PCBranchD, 32'h4C);

    // Writes to register 0 are ignored (decode holds beq $0,$0)
    StallD = 1; RegWriteW = 1; WriteRegW = 0; ResultW = 5;
    #1 check("r0.bypass", RD1_D, 32'd0);
    tick();
    RegWriteW = 0;
    #1 check("r0.after", RD1_D, 32'd0);

    // Load bne $8,$9 and set $8=7, $9=7
    StallD = 0; InstrF = 32'h1509_0002; PCPlus4F = 32'h100;
    RegWriteW = 1; WriteRegW = 8; ResultW = 7;
    tick();
    StallD = 1; WriteRegW = 9;
    tick();
    RegWriteW = 0; ALUOutM = 9; ResultW = 7;
    ForwardAD = 2'b00; #1 check("fwd00.eq", EqualD, 1'b1); check("fwd00.bt", BranchTakenD, 1'b0);
    ForwardAD = 2'b01; #1 check("fwd01.eq", EqualD, 1'b0); check("fwd01.bt", BranchTakenD, 1'b1);
    ForwardAD = 2'b10; #1 check("fwd10.eq", EqualD, 1'b1); check("fwd10.bt", BranchTakenD, 1'b0);
    ForwardAD = 2'b11; #1 check("fwd11.eq", EqualD, 1'b1); check("fwd11.bt", BranchTakenD, 1'b0);
    compare_outputs("fwd");
    ForwardAD = 2'b00;

    // Write-through of $8
    RegWriteW = 1; WriteRegW = 8; ResultW = 32'hDEAD_BEEF;
    #1 check("wt.same", RD1_D, 32'hDEAD_BEEF);
    tick();
    RegWriteW = 0; ResultW = 0;
    #1 check("wt.after", RD1_D, 32'hDEAD_BEEF);

    // Stall wins over flush, then flush alone
    StallD = 1; FlushD = 1; InstrF = 32'h0800_0001; PCPlus4F = 32'h5555;
    tick(); tick();
    check("stall.instr", InstrD, 32'h1509_0002);
    check("stall.pc4", PCPlus4D, 32'h100);
    check("stall.valid", ValidD, 1'b1);
    StallD = 0;
    tick();
    check("flush.instr", InstrD, 32'd0);
    check("flush.valid", ValidD, 1'b0);
    check("flush.bt", BranchTakenD, 1'b0);
    FlushD = 0;

    // Jump and sign extension
    InstrF = 32'h0800_0010; PCPlus4F = 32'h1000_0004;
    tick();
    check("jump.j", JumpD, 1'b1);
    check("jump.pcj", PCJumpD, 32'h1000_0040);
    InstrF = 32'h1000_FFFF; PCPlus4F = 32'h2000;
    tick();
    check("sext.imm", SignImmD, 32'hFFFF_FFFF);
    check("sext.pcb", PCBranchD, 32'h1FFC);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 3))
        0: op = 6'h04;
        1: op = 6'h05;
        2: op = 6'h02;
        default: op = 6'($urandom);
      endcase
      InstrF    = {op, 26'($urandom)};
      if ($urandom_range(0, 2) == 0) InstrF[25:16] = 10'($urandom_range(0, 3) * 33);
      PCPlus4F  = $urandom;
      RST       = ($urandom_range(0, 59) == 0);
      StallD    = ($urandom_range(0, 3) == 0);
      FlushD    = ($urandom_range(0, 5) == 0);
      RegWriteW = ($urandom_range(0, 1) == 0);
      WriteRegW = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ResultW   = rand_val();
      ALUOutM   = rand_val();
      ForwardAD = 2'($urandom);
      ForwardBD = 2'($urandom);
      #1 compare_outputs($sformatf("rnd%0d", n));
      tick();
    end
    RST = 0;

    // 64-bit datapath, 8-entry regfile
    tick();
    p_rst = 0;
    p_instr_f = 32'h117F_0001;            // beq rs=01011 rt=11111 imm=1
    p_pc_f = 64'hFFFF_FFFF_FFFF_FFFC;
    p_we = 1; p_wa = 3; p_wd = 64'h1234_5678_9ABC_DEF0;
    tick();
    p_stall = 1; p_wa = 7; p_wd = 64'hCAFE_F00D_0000_0001;
    tick();
    p_we = 0; p_wd = 0;
    #1;
    check("p64.rs", p_rs, 3'd3);
    check("p64.rt", p_rt, 3'd7);
    check("p64.rd1", p_rd1, 64'h1234_5678_9ABC_DEF0);
    check("p64.rd2", p_rd2, 64'hCAFE_F00D_0000_0001);
    check("p64.pcb", p_pcb, 64'd0);
    check("p64.imm", p_imm, 64'd1);
    check("p64.eq", p_eq, 1'b0);
    check("p64.bt", p_bt, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised decode stage for the pipelined MIPS core. It owns the IF/ID pipeline register (with stall, flush and valid tracking), a reset-cleared register file with write-through bypass, and three-way operand forwarding for early branch resolution. It resolves BEQ/BNE in Decode and produces branch and jump targets. It sits between the fetch stage and the ID/EX register, and is driven by the hazard unit.

## Interface
- DATA_W, 32, datapath width; must be ≥ 32.
- REG_AW, 5, register-file address width (2**REG_AW registers). Instruction fields stay at MIPS positions; only the low REG_AW bits of each 5-bit field are used.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- InstrF  in  32  fetched instruction.
- PCPlus4F  in  DATA_W  fetch PC+4.
- StallD  in  1  hold the IF/ID register.
- FlushD  in  1  load a bubble into IF/ID.
- RegWriteW  in  1  writeback enable.
- WriteRegW  in  REG_AW  writeback address.
- ResultW  in  DATA_W  writeback data.
- ALUOutM  in  DATA_W  Memory-stage ALU result.
- ForwardAD, ForwardBD  in  2 each  operand source select: 00 regfile, 01 ALUOutM, 10 ResultW, 11 regfile.
- InstrD  out  32  registered instruction.
- PCPlus4D  out  DATA_W  registered PC+4.
- ValidD  out  1  Decode holds a real instruction.
- RD1_D, RD2_D  out  DATA_W  regfile read data after bypass, before forwarding.
- SignImmD  out  DATA_W  InstrD[15:0] sign-extended.
- PCBranchD  out  DATA_W  (SignImmD<<2) + PCPlus4D, modulo 2**DATA_W.
- PCJumpD  out  DATA_W  {PCPlus4D[DATA_W-1:28], InstrD[25:0], 2'b00}.
- RsD, RtD, RdD  out  REG_AW  InstrD[25:21], InstrD[20:16], InstrD[15:11], each truncated to REG_AW.
- EqualD  out  1  forwarded operand A == forwarded operand B.
- BranchTakenD  out  1  ValidD & ((op==BEQ & EqualD) | (op==BNE & ~EqualD)).
- JumpD  out  1  ValidD & (op==J).

## Operation
- **IF/ID register.** Priority is RST > StallD > FlushD > load.
  - RST or flush: InstrD=0 (NOP), PCPlus4D=0, ValidD=0.
  - Stall: all three hold. Stall wins over a simultaneous flush.
  - Load: InstrF, PCPlus4F and ValidD=1.
- **Register file.**
  - 2**REG_AW × DATA_W entries. Reset clears every entry to 0.
  - A write at the clock edge when RegWriteW=1 and WriteRegW≠0.
  - Register 0 always reads 0; writes to it are ignored.
  - Reads are combinational on RsD/RtD.
  - Write-through bypass: if RegWriteW and WriteRegW equals the read address (≠0), the read returns ResultW in the same cycle.
- **Forwarding.**
  - Operand A is chosen by ForwardAD from {RD1_D, ALUOutM, ResultW}.
  - Operand B is chosen by ForwardBD from {RD2_D, ALUOutM, ResultW}.
  - Encoding 11 behaves as 00.
- **Opcode decode.** Opcodes are BEQ=6'h04, BNE=6'h05, J=6'h02. Other opcodes give BranchTakenD=JumpD=0.
- **Qualification.** BranchTakenD and JumpD are not gated by StallD; the hazard unit must mask them during a stall.
- **Arithmetic.** All additions wrap modulo 2**DATA_W.
- **Hazard detection.** This block performs none.

## Timing
- IF/ID latency is one cycle: InstrF sampled at edge k appears on InstrD after edge k.
- All other outputs are combinational from IF/ID state, the register file and the forwarding inputs. Operands resolve in the same cycle.
- A regfile write at edge k is visible through the array after edge k, and through the bypass during the cycle before edge k.
- Reset values:
  - InstrD, PCPlus4D, ValidD, RsD/RtD/RdD, SignImmD are all 0.
  - PCBranchD=0, PCJumpD=0.
  - RD1_D=RD2_D=0, unless the writeback bypass is active.
  - EqualD=1 when both operands are 0.
  - BranchTakenD=JumpD=0.
- RST asserted mid-stall clears IF/ID and the register file on the same edge.

## Structure
- **Package decode_pkg** holds:
  - opcode constants OP_BEQ, OP_BNE, OP_J;
  - forwarding-select constants FWD_RF, FWD_M, FWD_W;
  - the NOP encoding.
- **Sub-module decode_regfile** is parametrised on DATA_W/REG_AW. It contains the array, the zero-register rule and the write-through bypass.
- IF/ID register, forwarding muxes, comparator, extend/shift, adder and opcode decode sit in the top module.

## Test plan
- **Reset.** RST=1 for 2 cycles, then release with StallD=0, InstrF=32'h1000_0003 (beq $0,$0,+3), PCPlus4F=32'h40.
  - Before release: ValidD=0, InstrD=0.
  - After the next edge: EqualD=1, BranchTakenD=1, PCBranchD=32'h4C.
- **Write-through.** RegWriteW=1, WriteRegW=8, ResultW=32'hDEAD_BEEF while InstrD reads rs=8.
  - RD1_D=32'hDEAD_BEEF in the same cycle, and it persists after the edge.
  - A write to reg 0 with value 5 leaves reads of reg 0 at 0.
- **Forwarding with BNE.** Decode holds bne $8,$9; $8=7, $9=7; ALUOutM=9, ResultW=7.
  - ForwardAD=00, ForwardBD=00: EqualD=1, BranchTakenD=0.
  - ForwardAD=01: EqualD=0, BranchTakenD=1.
  - ForwardAD=10: EqualD=1, BranchTakenD=0.
  - ForwardAD=11 behaves as 00.
- **Stall vs flush.** StallD=1 and FlushD=1 together for 2 cycles: InstrD/PCPlus4D/ValidD are unchanged. Then FlushD=1 alone: InstrD=0, ValidD=0, BranchTakenD=0.
- **Jump and sign extension.** InstrD=32'h0800_0010 with PCPlus4D=32'h1000_0004 gives JumpD=1, PCJumpD=32'h1000_0040. Immediate 16'hFFFF gives SignImmD=32'hFFFF_FFFF and PCBranchD=PCPlus4D-4.
- **Parametrisation.** With DATA_W=64, REG_AW=3:
  - rs field 5'b01011 selects reg 3;
  - the regfile has 8 entries;
  - PCBranchD wraps at 2**64 (PCPlus4D=64'hFFFF_FFFF_FFFF_FFFC, imm=1 gives 0).
